id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID→EX pipeline register sitting directly downstream of the immediate sign-extender in the decode stage.
- Captures the 32-bit extended immediate, both register-file read operands, register addresses and the decoded control bundle.
- Presents them to the execute stage one cycle later.
- Supports hazard-unit stall and branch flush, tracks slot validity, and protects the stored immediate with a parity bit. Any upset while the value is held is flagged for fault tracking.

Parameters:
- DATA_W, 32, width of immediate and operand data paths
- CTRL_W, 8, width of decoded control bundle (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp[2:0])

Ports:
- clk_i  in  1  clock, rising-edge
- rst_i  in  1  asynchronous, active-low reset
- stall_i  in  1  hold all stage contents (from hazard unit)
- flush_i  in  1  replace incoming slot with a bubble (from branch resolution)
- valid_i  in  1  ID slot holds a real instruction
- imm_i  in  DATA_W  sign-extended immediate from decode
- rs1_data_i  in  DATA_W  register-file read port 1
- rs2_data_i  in  DATA_W  register-file read port 2
- rs1_addr_i  in  5  source register 1 index
- rs2_addr_i  in  5  source register 2 index
- rd_addr_i  in  5  destination register index
- funct_i  in  4  {funct7[5], funct3}
- ctrl_i  in  CTRL_W  decoded control bundle
- valid_o  out  1  EX slot holds a real instruction
- imm_o  out  DATA_W  registered immediate
- rs1_data_o  out  DATA_W  registered operand 1
- rs2_data_o  out  DATA_W  registered operand 2
- rs1_addr_o  out  5  registered rs1 index
- rs2_addr_o  out  5  registered rs2 index
- rd_addr_o  out  5  registered rd index
- funct_o  out  4  registered funct
- ctrl_o  out  CTRL_W  registered control, forced 0 for bubbles
- parity_err_o  out  1  sticky: stored immediate failed parity check
- bubble_cnt_o  out  16  count of bubbles inserted, saturating

Behaviour:
- Reset (rst_i=0, asynchronous): all outputs 0, including the internal parity bit, valid_o, parity_err_o and bubble_cnt_o. Release takes effect at the next rising edge.
- Latency: 1 cycle, input to output.
- Priority at each rising edge is flush > stall > load.
- Flush (flush_i=1, regardless of stall_i):
  - valid_o←0, ctrl_o←0, rd_addr_o←0.
  - Data, address and funct fields are loaded from the inputs (don't-care for bubbles).
  - Parity bit recomputed from imm_i.
  - bubble_cnt_o increments.
- Stall (stall_i=1, flush_i=0): every register holds, parity bit included. bubble_cnt_o unchanged.
- Load (stall_i=0, flush_i=0):
  - All fields ← inputs; valid_o ← valid_i.
  - ctrl_o ← valid_i ? ctrl_i : 0.
  - If valid_i=0, bubble_cnt_o increments.
- Parity:
  - Internal bit p ← ^imm_i whenever the immediate register loads.
  - Each cycle, compare ^imm_o with p. A mismatch sets parity_err_o at the next edge.
  - parity_err_o stays set until reset.
  - No check is made when valid_o=0.
- bubble_cnt_o saturates at 16'hFFFF; it does not wrap.
- Reset asserted mid-stall or mid-flush clears immediately. There is no pending state.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_i=0 with random inputs and clocks running → all outputs 0. Release, load imm_i=32'hFFFFF800 with valid_i=1 → next cycle imm_o=32'hFFFFF800, valid_o=1, parity_err_o=0.
- Stall: load ctrl_i=8'hA5, rd_addr_i=5'd7, then stall_i=1 for 3 cycles while inputs change → outputs stay 8'hA5 / 7. Deassert stall → new inputs appear one cycle later.
- Flush over stall: stall_i=1 and flush_i=1 with valid_i=1, ctrl_i=8'hFF → valid_o=0, ctrl_o=0, rd_addr_o=0, bubble_cnt_o 0→1.
- Bubble counting: 5 cycles of valid_i=0 with no stall → bubble_cnt_o=5. Force the count to 16'hFFFE, insert 3 bubbles → reads 16'hFFFF.
- Parity fault: load imm_i=32'h00000001, then force-flip imm_o bit 4 for one cycle → parity_err_o=1 next cycle and remains 1 after the force is released, until rst_i=0.
- Async reset mid-operation: assert rst_i between clock edges during a stall → outputs go to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX stage bundle: decode-side inputs and execute-side registered outputs.
// The master drives the decode side and observes the EX side; the pipe register is the slave.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [4:0]        rs1_addr_i;
  logic [4:0]        rs2_addr_i;
  logic [4:0]        rd_addr_i;
  logic [3:0]        funct_i;
  logic [CTRL_W-1:0] ctrl_i;

  logic              valid_o;
  logic [DATA_W-1:0] imm_o;
  logic [DATA_W-1:0] rs1_data_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic [4:0]        rs1_addr_o;
  logic [4:0]        rs2_addr_o;
  logic [4:0]        rd_addr_o;
  logic [3:0]        funct_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic              parity_err_o;
  logic [15:0]       bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, imm_i, rs1_data_i, rs2_data_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i, ctrl_i,
    input  valid_o, imm_o, rs1_data_o, rs2_data_o, rs1_addr_o, rs2_addr_o,
           rd_addr_o, funct_o, ctrl_o, parity_err_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, imm_i, rs1_data_i, rs2_data_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i, ctrl_i,
    output valid_o, imm_o, rs1_data_o, rs2_data_o, rs1_addr_o, rs2_addr_o,
           rd_addr_o, funct_o, ctrl_o, parity_err_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with stall/flush, slot validity, saturating bubble count
// and a parity-protected immediate whose held value is continuously checked.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  id_ex_pipe_reg_if.slave    bus
);

  function automatic logic parity_f(input logic [DATA_W-1:0] value);
    return ^value;
  endfunction

  logic              valid_q,    valid_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q,  rd_addr_d;
  logic [3:0]        funct_q,    funct_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic              par_q,      par_d;
  logic              perr_q,     perr_d;
  logic [15:0]       bcnt_q,     bcnt_d;
  logic              bubble_s;
  logic              par_mismatch_s;

  // The check reads the presented immediate, so an upset on the output path is seen too.
  assign par_mismatch_s = valid_q & (parity_f(bus.imm_o) != par_q);

  // Next-state selection: flush beats stall beats load.
  always_comb begin
    valid_d    = valid_q;
    imm_d      = imm_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    funct_d    = funct_q;
    ctrl_d     = ctrl_q;
    par_d      = par_q;
    bubble_s   = 1'b0;
    if (bus.flush_i) begin
      valid_d    = 1'b0;
      imm_d      = bus.imm_i;
      rs1_data_d = bus.rs1_data_i;
      rs2_data_d = bus.rs2_data_i;
      rs1_addr_d = bus.rs1_addr_i;
      rs2_addr_d = bus.rs2_addr_i;
      rd_addr_d  = 5'd0;
      funct_d    = bus.funct_i;
      ctrl_d     = '0;
      par_d      = parity_f(bus.imm_i);
      bubble_s   = 1'b1;
    end else if (!bus.stall_i) begin
      valid_d    = bus.valid_i;
      imm_d      = bus.imm_i;
      rs1_data_d = bus.rs1_data_i;
      rs2_data_d = bus.rs2_data_i;
      rs1_addr_d = bus.rs1_addr_i;
      rs2_addr_d = bus.rs2_addr_i;
      rd_addr_d  = bus.rd_addr_i;
      funct_d    = bus.funct_i;
      ctrl_d     = bus.valid_i ? bus.ctrl_i : '0;
      par_d      = parity_f(bus.imm_i);
      bubble_s   = ~bus.valid_i;
    end else begin
      bubble_s   = 1'b0;
    end

    if (bubble_s && (bcnt_q != 16'hFFFF)) begin
      bcnt_d = bcnt_q + 16'd1;
    end else begin
      bcnt_d = bcnt_q;
    end

    perr_d = perr_q | par_mismatch_s;
  end

  // Stage state; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_addr_q  <= 5'd0;
      funct_q    <= 4'd0;
      ctrl_q     <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      bcnt_q     <= 16'd0;
    end else begin
      valid_q    <= valid_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      funct_q    <= funct_d;
      ctrl_q     <= ctrl_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      bcnt_q     <= bcnt_d;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.imm_o        = imm_q;
  assign bus.rs1_data_o   = rs1_data_q;
  assign bus.rs2_data_o   = rs2_data_q;
  assign bus.rs1_addr_o   = rs1_addr_q;
  assign bus.rs2_addr_o   = rs2_addr_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.funct_o      = funct_q;
  assign bus.ctrl_o       = ctrl_q;
  assign bus.parity_err_o = perr_q;
  assign bus.bubble_cnt_o = bcnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed-vector bench for id_ex_pipe_reg with hand-computed expectations.
module tb_id_ex_pipe_reg;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  id_ex_pipe_reg_if #(.DATA_W(32), .CTRL_W(8)) bus ();

  id_ex_pipe_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic stall, input logic flush, input logic valid,
                       input logic [31:0] imm, input logic [7:0] ctrl, input logic [4:0] rd);
    bus.stall_i   = stall;
    bus.flush_i   = flush;
    bus.valid_i   = valid;
    bus.imm_i     = imm;
    bus.ctrl_i    = ctrl;
    bus.rd_addr_i = rd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, "_imm"},   bus.imm_o, 32'd0);
    chk({tag, "_rs1"},   bus.rs1_data_o, 32'd0);
    chk({tag, "_ctrl"},  {24'd0, bus.ctrl_o}, 32'd0);
    chk({tag, "_rd"},    {27'd0, bus.rd_addr_o}, 32'd0);
    chk({tag, "_perr"},  {31'd0, bus.parity_err_o}, 32'd0);
    chk({tag, "_bcnt"},  {16'd0, bus.bubble_cnt_o}, 32'd0);
  endtask

  initial begin
    bus.rs1_data_i = 32'd0;
    bus.rs2_data_i = 32'd0;
    bus.rs1_addr_i = 5'd0;
    bus.rs2_addr_i = 5'd0;
    bus.funct_i    = 4'd0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 5'd0);

    // Reset held with random inputs and running clock
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, 8'($urandom), 5'($urandom));
      bus.rs1_data_i = $urandom;
      tick();
      chk_all_zero("rst");
    end

    // Release and load first immediate
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFFF800, 8'h11, 5'd3);
    bus.rs1_data_i = 32'h12345678;
    tick();
    chk("load_imm",   bus.imm_o, 32'hFFFFF800);
    chk("load_valid", {31'd0, bus.valid_o}, 32'd1);
    chk("load_perr",  {31'd0, bus.parity_err_o}, 32'd0);
    chk("load_rs1",   bus.rs1_data_o, 32'h12345678);
    chk("load_bcnt",  {16'd0, bus.bubble_cnt_o}, 32'd0);

    // Stall holds contents while inputs change
    drive(1'b0, 1'b0, 1'b1, 32'h00000010, 8'hA5, 5'd7);
    tick();
    chk("stl_pre_ctrl", {24'd0, bus.ctrl_o}, 32'h000000A5);
    chk("stl_pre_rd",   {27'd0, bus.rd_addr_o}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h00000020 + 32'(i), 8'h3C, 5'd9);
      tick();
      chk("stl_ctrl", {24'd0, bus.ctrl_o}, 32'h000000A5);
      chk("stl_rd",   {27'd0, bus.rd_addr_o}, 32'd7);
      chk("stl_imm",  bus.imm_o, 32'h00000010);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h00000022, 8'h3C, 5'd9);
    tick();
    chk("unstl_ctrl", {24'd0, bus.ctrl_o}, 32'h0000003C);
    chk("unstl_rd",   {27'd0, bus.rd_addr_o}, 32'd9);
    chk("unstl_bcnt", {16'd0, bus.bubble_cnt_o}, 32'd0);

    // Flush overrides stall
    drive(1'b1, 1'b1, 1'b1, 32'h00000040, 8'hFF, 5'd12);
    bus.rs1_data_i = 32'hDEADBEEF;
    tick();
    chk("fl_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("fl_ctrl",  {24'd0, bus.ctrl_o}, 32'd0);
    chk("fl_rd",    {27'd0, bus.rd_addr_o}, 32'd0);
    chk("fl_bcnt",  {16'd0, bus.bubble_cnt_o}, 32'd1);
    chk("fl_rs1",   bus.rs1_data_o, 32'hDEADBEEF);

    // Five unstalled bubbles: count goes 1 -> 6, ctrl forced 0
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h00000100, 8'hFF, 5'd5);
      tick();
      chk("bub_ctrl", {24'd0, bus.ctrl_o}, 32'd0);
    end
    chk("bub_bcnt", {16'd0, bus.bubble_cnt_o}, 32'd6);
    chk("bub_rd",   {27'd0, bus.rd_addr_o}, 32'd5);

    // Stalled invalid slots do not count
    drive(1'b1, 1'b0, 1'b0, 32'h00000100, 8'hFF, 5'd5);
    tick();
    tick();
    chk("stlbub_bcnt", {16'd0, bus.bubble_cnt_o}, 32'd6);

    // Saturation from 16'hFFFE
    force dut.bcnt_q = 16'hFFFE;
    #1;
    release dut.bcnt_q;
    chk("sat_pre", {16'd0, bus.bubble_cnt_o}, 32'h0000FFFE);
    drive(1'b0, 1'b0, 1'b0, 32'h00000100, 8'h00, 5'd0);
    tick();
    chk("sat_1", {16'd0, bus.bubble_cnt_o}, 32'h0000FFFF);
    tick();
    tick();
    chk("sat_3", {16'd0, bus.bubble_cnt_o}, 32'h0000FFFF);

    // Upset on an invalid slot is not checked
    drive(1'b0, 1'b0, 1'b0, 32'h00000001, 8'h00, 5'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h00000001, 8'h00, 5'd0);
    force bus.imm_o = 32'h00000011;
    tick();
    release bus.imm_o;
    #1;
    chk("inv_perr", {31'd0, bus.parity_err_o}, 32'd0);

    // Parity fault on a valid held immediate is sticky
    @(negedge clk_i);
    drive(1'b0, 1'b0, 1'b1, 32'h00000001, 8'h42, 5'd1);
    tick();
    chk("par_imm",  bus.imm_o, 32'h00000001);
    chk("par_pre",  {31'd0, bus.parity_err_o}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h00000003, 8'h42, 5'd1);
    force bus.imm_o = 32'h00000011;
    tick();
    release bus.imm_o;
    #1;
    chk("par_set",  {31'd0, bus.parity_err_o}, 32'd1);
    chk("par_rest", bus.imm_o, 32'h00000001);
    @(negedge clk_i);
    tick();
    chk("par_stky", {31'd0, bus.parity_err_o}, 32'd1);

    // Asynchronous reset between edges during a stall
    #2;
    rst_i = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 32'h00000007, 8'h81, 5'd4);
    tick();
    chk("post_imm",  bus.imm_o, 32'h00000007);
    chk("post_ctrl", {24'd0, bus.ctrl_o}, 32'h00000081);
    chk("post_perr", {31'd0, bus.parity_err_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
